// File: rtl/lwei_pkg.sv
// lwei_pkg: shared constants and loader state type for the lwei weight path
package lwei_pkg;
   localparam int          WORD_W            = 32;
   localparam logic [31:0] LWEI_BASE_ADDRESS = 32'h3000_0000;
   localparam int          ARRAY_SIZE        = 4;
   localparam int          CHANNEL           = 1;
   localparam int          INPUT_SIZE        = 8;
   localparam int          KERNEL_SIZE       = 3;
   typedef enum logic [1:0] {IDLE, REQ, GAP, FIN} loader_state_t;
endpackage

// File: rtl/lwei_loader.sv
// lwei_loader: Wishbone classic initiator writing a latched weight bank to the lwei responder
module lwei_loader
   import lwei_pkg::*;
#(
   parameter logic [31:0] TARGET_ADDRESS = LWEI_BASE_ADDRESS,
   parameter int          NUM_WORDS      = 4,
   parameter int          TIMEOUT_CYCLES = 64
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [NUM_WORDS*WORD_W-1:0] weights_in,
   output logic                        busy,
   output logic                        done,
   output logic                        err,
   output logic [3:0]                  words_sent,
   output logic                        wbm_cyc_o,
   output logic                        wbm_stb_o,
   output logic                        wbm_we_o,
   output logic [3:0]                  wbm_sel_o,
   output logic [31:0]                 wbm_adr_o,
   output logic [31:0]                 wbm_dat_o,
   input  logic                        wbm_ack_i
);
   loader_state_t               state_q, state_d;
   logic [NUM_WORDS*WORD_W-1:0] bank_q, bank_d;
   logic [3:0]                  idx_q, idx_d, sent_q, sent_d;
   logic [7:0]                  to_q, to_d;
   logic                        err_q, err_d;
   logic [WORD_W-1:0]           word;
   logic                        req;
   // state and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         bank_q  <= '0;
         idx_q   <= '0;
         sent_q  <= '0;
         to_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         bank_q  <= bank_d;
         idx_q   <= idx_d;
         sent_q  <= sent_d;
         to_q    <= to_d;
         err_q   <= err_d;
      end
   end
   // next state: GAP always follows an ack so the responder's late ack cannot repeat a write
   always_comb begin
      state_d = state_q;
      bank_d  = bank_q;
      idx_d   = idx_q;
      sent_d  = sent_q;
      to_d    = to_q;
      err_d   = err_q;
      case (state_q)
         IDLE: if (start) begin
            bank_d  = weights_in;
            idx_d   = '0;
            sent_d  = '0;
            to_d    = '0;
            err_d   = 1'b0;
            state_d = REQ;
         end
         REQ: if (wbm_ack_i) begin
            sent_d  = sent_q + 4'd1;
            idx_d   = idx_q + 4'd1;
            state_d = GAP;
         end else if (to_q == 8'(TIMEOUT_CYCLES - 1)) begin
            err_d   = 1'b1;
            state_d = FIN;
         end else begin
            to_d = (to_q == 8'hFF) ? to_q : to_q + 8'd1;
         end
         GAP: begin
            to_d    = '0;
            state_d = (idx_q < 4'(NUM_WORDS)) ? REQ : FIN;
         end
         default: state_d = IDLE;
      endcase
   end
   // select the current word from the latched bank
   always_comb begin
      word = '0;
      for (int k = 0; k < NUM_WORDS; k++)
         if (idx_q == 4'(k)) word = bank_q[k*WORD_W +: WORD_W];
   end
   assign req        = (state_q == REQ);
   assign wbm_cyc_o  = req;
   assign wbm_stb_o  = req;
   assign wbm_we_o   = req;
   assign wbm_sel_o  = req ? 4'hF : 4'h0;
   assign wbm_adr_o  = req ? TARGET_ADDRESS : 32'h0;
   assign wbm_dat_o  = req ? word : 32'h0;
   assign busy       = req || (state_q == GAP);
   assign done       = (state_q == FIN);
   assign err        = err_q;
   assign words_sent = sent_q;
endmodule
